led_fade_driver: RTL and testbench

//  Sits downstream of the dual-core SoC top level and consumes its two 32-bit status registers.

---
 rtl/led_fade_if.sv | 14 +
 rtl/led_fade_driver.sv | 127 ++++++++++++
 tb/tb_led_fade_driver.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/led_fade_if.sv
// Status/LED bundle between the SoC status registers and the LED fade driver.
// The master supplies the enable and the two core status words; the slave drives the LEDs.
interface led_fade_if #(
    parameter int SRC_WIDTH = 32
);
    logic                 enable;
    logic [SRC_WIDTH-1:0] reg0;
    logic [SRC_WIDTH-1:0] reg1;
    logic [3:0]           led;
    logic                 fading;

    modport master (output enable, reg0, reg1, input  led, fading);
    modport slave  (input  enable, reg0, reg1, output led, fading);
endinterface

// File: rtl/led_fade_driver.sv
// Four-LED driver: per-core 2-bit target fields, linear brightness fade on a
// prescaled tick, and free-running PWM rendering with registered outputs.
module led_fade_driver #(
    parameter int SRC_WIDTH = 32,
    parameter int SRC_LSB   = 19,
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 1000,
    parameter int FADE_STEP = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    led_fade_if.slave  bus
);
    localparam int NLED = 4;
    localparam int PCW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PWM_BITS-1:0] BMAX  = {PWM_BITS{1'b1}};
    localparam logic [PCW-1:0]      PLAST = PCW'(PRESCALE - 1);
    localparam logic [PWM_BITS:0]   STEP  = (PWM_BITS + 1)'(FADE_STEP);

    typedef enum logic [1:0] {
        FADE_STEADY  = 2'd0,
        FADE_RISING  = 2'd1,
        FADE_FALLING = 2'd2
    } fade_e;

    logic [NLED-1:0]     tgt_q, tgt_d;
    logic [PWM_BITS-1:0] bri_q [NLED];
    logic [PWM_BITS-1:0] bri_d [NLED];
    logic [PCW-1:0]      presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [NLED-1:0]     led_q, led_d;
    logic                fading_q, fading_d;
    logic                tick_s;
    logic                reg_unused_s;

    function automatic fade_e fade_dir(input logic [PWM_BITS-1:0] bri,
                                       input logic [PWM_BITS-1:0] lvl);
        fade_e dir;
        if (bri < lvl) begin
            dir = FADE_RISING;
        end else if (bri > lvl) begin
            dir = FADE_FALLING;
        end else begin
            dir = FADE_STEADY;
        end
        return dir;
    endfunction

    // Rising sums carry one extra bit so the top step saturates at BMAX instead of wrapping.
    function automatic logic [PWM_BITS-1:0] fade_next(input logic [PWM_BITS-1:0] bri,
                                                      input logic [PWM_BITS-1:0] lvl);
        logic [PWM_BITS:0]   sum;
        logic [PWM_BITS-1:0] res;
        sum = {1'b0, bri} + STEP;
        case (fade_dir(bri, lvl))
            FADE_RISING:  res = (sum > {1'b0, BMAX}) ? BMAX : sum[PWM_BITS-1:0];
            FADE_FALLING: res = ({1'b0, bri} < STEP) ? {PWM_BITS{1'b0}}
                                                     : (bri - STEP[PWM_BITS-1:0]);
            FADE_STEADY:  res = bri;
            default:      res = bri;
        endcase
        return res;
    endfunction

    // Only the two LED fields of each status word matter; the rest is deliberately dropped.
    assign reg_unused_s = ^{bus.reg0, bus.reg1};

    // Next-state for target capture, prescaler, PWM counter, brightness and outputs.
    always_comb begin
        tgt_d    = {bus.reg0[SRC_LSB+1:SRC_LSB], bus.reg1[SRC_LSB+1:SRC_LSB]};
        tick_s   = bus.enable && (presc_q == PLAST);
        presc_d  = presc_q;
        pwm_d    = pwm_q;
        fading_d = 1'b0;
        led_d    = {NLED{1'b0}};
        if (!bus.enable) begin
            presc_d = presc_q;
            pwm_d   = pwm_q;
        end else if (tick_s) begin
            presc_d = {PCW{1'b0}};
            pwm_d   = pwm_q + PWM_BITS'(1);
        end else begin
            presc_d = presc_q + PCW'(1);
            pwm_d   = pwm_q + PWM_BITS'(1);
        end
        // The tick consults tgt_q, so a target change on a tick cycle only counts from the next tick.
        for (int i = 0; i < NLED; i++) begin
            if (tick_s) begin
                bri_d[i] = fade_next(bri_q[i], tgt_q[i] ? BMAX : {PWM_BITS{1'b0}});
            end else begin
                bri_d[i] = bri_q[i];
            end
            led_d[i] = bus.enable && ((bri_q[i] == BMAX) || (bri_q[i] > pwm_q));
            if (bri_q[i] != (tgt_q[i] ? BMAX : {PWM_BITS{1'b0}})) begin
                fading_d = 1'b1;
            end else begin
                fading_d = fading_d;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tgt_q    <= {NLED{1'b0}};
            presc_q  <= {PCW{1'b0}};
            pwm_q    <= {PWM_BITS{1'b0}};
            led_q    <= {NLED{1'b0}};
            fading_q <= 1'b0;
            for (int i = 0; i < NLED; i++) begin
                bri_q[i] <= {PWM_BITS{1'b0}};
            end
        end else begin
            tgt_q    <= tgt_d;
            presc_q  <= presc_d;
            pwm_q    <= pwm_d;
            led_q    <= led_d;
            fading_q <= fading_d;
            for (int i = 0; i < NLED; i++) begin
                bri_q[i] <= bri_d[i];
            end
        end
    end

    assign bus.led    = led_q;
    assign bus.fading = fading_q;
endmodule

// File: tb/tb_led_fade_driver.sv
// Randomized bench for led_fade_driver against a cycle-level arithmetic model,
// plus a slow second instance used to measure PWM duty at a held brightness.
module tb_led_fade_driver;
    localparam int BMAXI = 255;
    localparam int PRESC = 4;
    localparam int STEPI = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_fade_if #(.SRC_WIDTH(32)) bus  ();
    led_fade_if #(.SRC_WIDTH(32)) bus2 ();

    led_fade_driver #(.SRC_WIDTH(32), .SRC_LSB(19), .PWM_BITS(8),
                      .PRESCALE(PRESC), .FADE_STEP(STEPI)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    led_fade_driver #(.SRC_WIDTH(32), .SRC_LSB(19), .PWM_BITS(8),
                      .PRESCALE(1024), .FADE_STEP(128)) dut2 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus2.slave)
    );

    int checks = 0;
    int errors = 0;

    int         m_bri [4];
    int         m_tgt [4];
    int         m_presc;
    int         m_pwm;
    logic [3:0] e_led;
    logic       e_fad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_bri[i] = 0;
            m_tgt[i] = 0;
        end
        m_presc = 0;
        m_pwm   = 0;
        e_led   = 4'b0000;
        e_fad   = 1'b0;
    endtask

    // One rising clock edge of the reference: outputs from the pre-edge state, then state update.
    task automatic model_edge();
        logic [3:0] nl;
        logic       nf;
        bit         tick;
        int         lvl;
        nf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lvl   = m_tgt[i] * BMAXI;
            nl[i] = bus.enable && (m_bri[i] == BMAXI || m_bri[i] > m_pwm);
            if (m_bri[i] != lvl) nf = 1'b1;
        end
        tick = bus.enable && (m_presc == PRESC - 1);
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                lvl = m_tgt[i] * BMAXI;
                if (m_bri[i] < lvl)      m_bri[i] = (m_bri[i] + STEPI > BMAXI) ? BMAXI : m_bri[i] + STEPI;
                else if (m_bri[i] > lvl) m_bri[i] = (m_bri[i] < STEPI) ? 0 : m_bri[i] - STEPI;
            end
        end
        if (bus.enable) begin
            m_presc = (m_presc + 1) % PRESC;
            m_pwm   = (m_pwm + 1) % (BMAXI + 1);
        end
        m_tgt[3] = int'(bus.reg0[20]);
        m_tgt[2] = int'(bus.reg0[19]);
        m_tgt[1] = int'(bus.reg1[20]);
        m_tgt[0] = int'(bus.reg1[19]);
        e_led = nl;
        e_fad = nf;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
        chk("led", {28'd0, bus.led}, {28'd0, e_led});
        chk("fading", {31'd0, bus.fading}, {31'd0, e_fad});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Asynchronous pulse placed between clock edges; called right after a negedge.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_led", {28'd0, bus.led}, 32'd0);
        chk("rst_fading", {31'd0, bus.fading}, 32'd0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        bus.enable  = 1'b1;
        bus.reg0    = 32'hFFFF_FFFF;
        bus.reg1    = 32'hFFFF_FFFF;
        bus2.enable = 1'b1;
        bus2.reg0   = 32'h0000_0000;
        bus2.reg1   = 32'h0008_0000;
        model_reset();

        @(negedge clk);
        run(5);

        rst_n    = 1'b1;
        bus.reg0 = 32'h0000_0000;
        bus.reg1 = 32'h0008_0000;
        run(30);

        // Pull the target away once brightness reaches 192 mid-rise.
        bus.reg1 = 32'h0000_0000;
        run(30);
        bus.reg1 = 32'h0008_0000;
        for (int k = 0; k < 64 && m_bri[0] != 192; k++) cycle();
        bus.reg1 = 32'hFFF7_FFFF;
        run(20);

        bus.reg1 = 32'h0008_0000;
        for (int k = 0; k < 64 && m_bri[0] != 64; k++) cycle();
        bus.enable = 1'b0;
        run(100);
        bus.enable = 1'b1;
        run(30);

        bus.reg0 = 32'h0018_0000;
        bus.reg1 = 32'h0000_0000;
        run(6);
        pulse_reset();
        run(30);

        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 15) == 0) bus.reg0 = $urandom;
            if ($urandom_range(0, 15) == 0) bus.reg1 = $urandom;
            bus.enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else                             cycle();
        end

        // Duty measurement on the slow instance: brightness sits at 128 between its first two ticks.
        bus.enable = 1'b1;
        pulse_reset();
        run(1100);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            cycle();
            if (bus2.led[0]) cnt++;
        end
        chk("duty128", cnt, 32'd128);
        chk("slow_fading", {31'd0, bus2.fading}, 32'd1);
        chk("slow_led_hi", {29'd0, bus2.led[3:1]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
